// File: rtl/wb_dest_tracker.sv
// rtl/wb_dest_tracker.sv - destination decode, in-order pending-write FIFO and RAW hazard flags
// Optional feature macro: WB_BYPASS_EN (head entry excluded from hazards while it commits)
module wb_dest_tracker #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  parameter int SP_REG = 29,
  parameter int RA_REG = 31
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [1:0]               RegWriteMUX,
  input  logic [ADDR_W-1:0]        rt_addr,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [ADDR_W-1:0]        issue_dest,
  input  logic                     commit_valid,
  output logic [ADDR_W-1:0]        commit_addr,
  output logic                     commit_we,
  input  logic [ADDR_W-1:0]        src_a,
  input  logic [ADDR_W-1:0]        src_b,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [ADDR_W-1:0] entry_addr [DEPTH];
  logic [DEPTH-1:0]  entry_valid;
  logic [DEPTH-1:0]  cmp_mask;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              empty;
  logic              issue_fire;
  logic              commit_fire;

  // Destination register decode from the write-select code
  always_comb begin
    issue_dest = rt_addr;
    case (RegWriteMUX)
      2'b00:   issue_dest = rt_addr;
      2'b01:   issue_dest = ADDR_W'(SP_REG);
      2'b10:   issue_dest = ADDR_W'(RA_REG);
      default: issue_dest = rd_addr;
    endcase
  end

  assign empty       = (count == '0);
  assign issue_ready = (count != FULL_CNT);
  assign issue_fire  = issue_valid && issue_ready;
  assign commit_fire = commit_valid && !empty;

  assign commit_addr = empty ? '0 : entry_addr[head];
  assign commit_we   = !empty && (commit_addr != '0);

  // Compare both sources against every outstanding write; register 0 never hazards
  always_comb begin
    cmp_mask = entry_valid;
`ifdef WB_BYPASS_EN
    if (commit_fire) begin
      cmp_mask[head] = 1'b0;
    end
`endif
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cmp_mask[i] && (entry_addr[i] == src_a) && (src_a != '0)) hazard_a = 1'b1;
      if (cmp_mask[i] && (entry_addr[i] == src_b) && (src_b != '0)) hazard_b = 1'b1;
    end
  end

  // Entry storage: write at tail on issue, retire the head on commit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry_valid <= '0;
    end else begin
      if (commit_fire) begin
        entry_valid[head] <= 1'b0;
      end
      if (issue_fire) begin
        entry_valid[tail] <= 1'b1;
        entry_addr[tail]  <= issue_dest;
      end
    end
  end

  // Pointers wrap naturally; count separates full from empty
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (issue_fire)  tail <= tail + PTR_ONE;
      if (commit_fire) head <= head + PTR_ONE;
      case ({issue_fire, commit_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky flag for a commit arriving with nothing pending
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      underflow_err <= 1'b0;
    end else if (commit_valid && empty) begin
      underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_dest_tracker.sv
// tb/tb_wb_dest_tracker.sv - self-checking bench for wb_dest_tracker against a queue model
module tb_wb_dest_tracker;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              issue_valid;
  logic              issue_ready;
  logic [1:0]        RegWriteMUX;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] issue_dest;
  logic              commit_valid;
  logic [ADDR_W-1:0] commit_addr;
  logic              commit_we;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] src_b;
  logic              hazard_a;
  logic              hazard_b;
  logic [2:0]        count;
  logic              underflow_err;

  int errors = 0;
  int checks = 0;
  int q[$];
  bit m_uf = 1'b0;
  int exp_dest[4];

  always #5 clk = ~clk;

  wb_dest_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SP_REG(29), .RA_REG(31)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .RegWriteMUX(RegWriteMUX), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .issue_dest(issue_dest),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_we(commit_we),
    .src_a(src_a), .src_b(src_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .count(count), .underflow_err(underflow_err)
  );

  function automatic int decode(input logic [1:0] sel, input int rt, input int rd);
    case (sel)
      2'b00:   return rt;
      2'b01:   return 29;
      2'b10:   return 31;
      default: return rd;
    endcase
  endfunction

  function automatic bit model_hazard(input int src);
    int first;
    first = 0;
`ifdef WB_BYPASS_EN
    if (commit_valid && q.size() != 0) first = 1;
`endif
    if (src == 0) return 1'b0;
    for (int i = first; i < q.size(); i++) begin
      if (q[i] == src) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int hd;
    hd = (q.size() != 0) ? q[0] : 0;
    chk("issue_dest", 32'(issue_dest), decode(RegWriteMUX, int'(rt_addr), int'(rd_addr)));
    chk("issue_ready", 32'(issue_ready), (q.size() != DEPTH) ? 1 : 0);
    chk("count", 32'(count), q.size());
    chk("commit_addr", 32'(commit_addr), hd);
    chk("commit_we", 32'(commit_we), (hd != 0) ? 1 : 0);
    chk("hazard_a", 32'(hazard_a), model_hazard(int'(src_a)));
    chk("hazard_b", 32'(hazard_b), model_hazard(int'(src_b)));
    chk("underflow_err", 32'(underflow_err), m_uf);
  endtask

  // Advance the model using the inputs present before the edge, then clock the DUT
  task automatic tick();
    int  s0;
    bit  hs;
    int  d;
    s0 = q.size();
    hs = issue_valid && (s0 != DEPTH);
    d  = decode(RegWriteMUX, int'(rt_addr), int'(rd_addr));
    if (!reset_n) begin
      q.delete();
      m_uf = 1'b0;
    end else begin
      if (commit_valid) begin
        if (s0 != 0) void'(q.pop_front());
        else m_uf = 1'b1;
      end
      if (hs) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input int rt);
    issue_valid = 1'b1; RegWriteMUX = 2'b00; rt_addr = ADDR_W'(rt);
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; issue_valid = 1'b0; commit_valid = 1'b0;
    RegWriteMUX = 2'b00; rt_addr = '0; rd_addr = '0; src_a = '0; src_b = '0;
    exp_dest[0] = 8; exp_dest[1] = 29; exp_dest[2] = 31; exp_dest[3] = 12;

    // Reset state
    tick();
    reset_n = 1'b1;
    #1;
    check_all();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(issue_ready), 1);

    // Decode table
    rt_addr = 5'd8; rd_addr = 5'd12;
    for (int i = 0; i < 4; i++) begin
      RegWriteMUX = 2'(i);
      #1;
      chk("decode", 32'(issue_dest), exp_dest[i]);
      check_all();
    end

    // Fill the FIFO, then a dropped fifth issue
    issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      RegWriteMUX = 2'(i);
      tick();
    end
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(issue_ready), 0);
    RegWriteMUX = 2'b00; rt_addr = 5'd5;
    tick();
    issue_valid = 1'b0;
    #1;
    check_all();
    chk("drop_count", 32'(count), 4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      chk("drain_addr", 32'(commit_addr), exp_dest[i]);
      chk("drain_we", 32'(commit_we), 1);
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
    end
    check_all();

    // Hazards, and destination 0 behaviour
    issue_one(9);
    src_a = 5'd9; src_b = 5'd0;
    #1;
    chk("haz_a9", 32'(hazard_a), 1);
    chk("haz_b0", 32'(hazard_b), 0);
    check_all();
    issue_one(0);
    src_a = 5'd0;
    #1;
    chk("haz_a0", 32'(hazard_a), 0);
    check_all();
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    #1;
    chk("zero_we", 32'(commit_we), 0);
    chk("zero_addr", 32'(commit_addr), 0);
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    check_all();

    // Simultaneous issue and commit at count 2, enough cycles to wrap
    issue_one(1);
    issue_one(2);
    for (int i = 0; i < 10; i++) begin
      issue_valid = 1'b1; commit_valid = 1'b1;
      RegWriteMUX = 2'b00; rt_addr = ADDR_W'(7 + i);
      #1;
      check_all();
      tick();
      chk("simul_count", 32'(count), 2);
    end
    issue_valid = 1'b0;
    chk("simul_head", 32'(commit_addr), 15);
    tick();
    tick();
    commit_valid = 1'b0;
    #1;
    check_all();

    // Underflow is sticky until reset
    commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0;
    #1;
    chk("uf_set", 32'(underflow_err), 1);
    chk("uf_count", 32'(count), 0);
    tick();
    chk("uf_hold", 32'(underflow_err), 1);
    issue_one(3);
    check_all();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    chk("uf_clear", 32'(underflow_err), 0);
    check_all();

    // Committing head versus hazard
    issue_one(9);
    src_a = 5'd9; commit_valid = 1'b1;
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_haz", 32'(hazard_a), 0);
`else
    chk("bypass_haz", 32'(hazard_a), 1);
`endif
    check_all();
    tick();
    commit_valid = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset_n      = ($urandom_range(0, 99) != 0);
      issue_valid  = ($urandom_range(0, 99) < 55);
      commit_valid = ($urandom_range(0, 99) < 45);
      RegWriteMUX  = 2'($urandom_range(0, 3));
      rt_addr      = ADDR_W'($urandom_range(0, 7));
      rd_addr      = ADDR_W'($urandom_range(0, 7));
      src_a        = ($urandom_range(0, 7) == 0) ? 5'd29 : ADDR_W'($urandom_range(0, 7));
      src_b        = ($urandom_range(0, 7) == 0) ? 5'd31 : ADDR_W'($urandom_range(0, 7));
      #1;
      check_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
